// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and datapath constants for the instruction-fetch stage
package fetch_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INSTR_W = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int PC_STEP = 4;
    typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer holding a fetched word that IF/ID could not take
module fetch_skid
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= INSTR_W'(NOP_INSTR);
            pc    <= '0;
        end else if (clear || (unload && !load)) begin
            valid <= 1'b0;
            instr <= INSTR_W'(NOP_INSTR);
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem req/ack fetch FSM and IF/ID register with skid buffer for decode back-pressure
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc4
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

    fetch_state_t state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, req_addr, target;
    logic accept, got_word, load_fetch, park, load_skid;
    logic skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    assign target     = redirect_pc_i & ~ADDR_W'(3);
    assign accept     = !ifid_valid || !stall_i;
    assign got_word   = state == FETCH && imem_ack && !redirect_i;
    assign load_fetch = got_word && accept;
    assign park       = got_word && !accept;
    assign load_skid  = state == FULL && accept && !redirect_i && skid_valid;
    // pc advances on every FETCH ack, even one dropped by a redirect (redirect then overrides it)
    assign pc_next    = redirect_i ? target : (state == FETCH && imem_ack) ? pc + STEP : pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // a request already on the bus cannot be withdrawn, so a redirect without ack drains it first
    always_comb begin
        state_next = state;
        if (redirect_i)
            state_next = ((state == FETCH || state == DRAIN) && !imem_ack) ? DRAIN : FETCH;
        else
            case (state)
                IDLE:    state_next = FETCH;
                FETCH:   state_next = (imem_ack && !accept) ? FULL : FETCH;
                FULL:    state_next = accept ? FETCH : FULL;
                DRAIN:   state_next = imem_ack ? FETCH : DRAIN;
                default: state_next = IDLE;
            endcase
    end

    always_comb begin
        imem_req  = state == FETCH || state == DRAIN;
        imem_addr = req_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP;
            ifid_pc    <= '0;
            ifid_pc4   <= '0;
        end else begin
            pc <= pc_next;
            if (state_next == FETCH)
                req_addr <= pc_next;
            if (redirect_i) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP;
            end else if (load_fetch) begin
                ifid_valid <= 1'b1;
                ifid_instr <= imem_rdata;
                ifid_pc    <= req_addr;
                ifid_pc4   <= req_addr + STEP;
            end else if (load_skid) begin
                ifid_valid <= 1'b1;
                ifid_instr <= skid_instr;
                ifid_pc    <= skid_pc;
                ifid_pc4   <= skid_pc + STEP;
            end else if (ifid_valid && !stall_i) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP;
            end
        end
    end

    fetch_skid #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) skid (
        .clk        (clk),
        .reset      (reset),
        .load       (park),
        .unload     (load_skid),
        .clear      (redirect_i),
        .load_instr (imem_rdata),
        .load_pc    (req_addr),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, multi-cycle corner sequences and randomized program-order check of fetch_stage
module tb_fetch_stage;
    logic clk = 1'b0, reset = 1'b1, imem_req, imem_ack = 1'b0, stall_i = 1'b0, redirect_i = 1'b0, ifid_valid;
    logic [31:0] imem_addr, imem_rdata = '0, redirect_pc_i = '0, ifid_instr, ifid_pc, ifid_pc4;
    int tests = 0, fails = 0;
    int mem_lat = 0, mem_cnt = 0, consumed = 0, n = 0;
    bit mem_rand = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] exp_pc = '0, prev_addr = '0;

    typedef struct {
        int stall;
        int redir;
        logic [31:0] rpc;
        int valid;
        logic [31:0] pc;
        int req;
        logic [31:0] addr;
    } vec_t;
    vec_t tbl[18];

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc4      (ifid_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic int pick_lat();
        return mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
    endfunction

    // memory: answers each request after pick_lat() waiting cycles, garbage data when not acking
    initial forever begin
        @(posedge clk);
        #1;
        if (reset) begin
            imem_ack = 1'b0;
            mem_cnt = pick_lat();
        end else if (imem_req && mem_cnt == 0) begin
            imem_ack = 1'b1;
            imem_rdata = tag(imem_addr);
            mem_cnt = pick_lat();
        end else begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            if (imem_req) mem_cnt--;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_state(input string nm, input int v, input logic [31:0] p, input int r, input logic [31:0] a);
        chk({nm, " valid"}, 32'(ifid_valid), 32'(v != 0));
        chk({nm, " req"}, 32'(imem_req), 32'(r != 0));
        if (r != 0) chk({nm, " addr"}, imem_addr, a);
        if (v != 0) begin
            chk({nm, " pc"}, ifid_pc, p);
            chk({nm, " pc4"}, ifid_pc4, p + 32'd4);
            chk({nm, " instr"}, ifid_instr, tag(p));
        end else
            chk({nm, " nop"}, ifid_instr, 32'h0);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " req"}, 32'(imem_req), 32'h0);
        chk({nm, " addr"}, imem_addr, 32'h0);
        chk({nm, " valid"}, 32'(ifid_valid), 32'h0);
        chk({nm, " instr"}, ifid_instr, 32'h0);
        chk({nm, " pc"}, ifid_pc, 32'h0);
        chk({nm, " pc4"}, ifid_pc4, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // zero-wait stream, 4-cycle stall into the skid, stall+redirect to 0x43, skid flush, wrap
        tbl[0]  = '{0, 0, 'h0, 0, 'h0, 1, 'h0};
        tbl[1]  = '{0, 0, 'h0, 1, 'h0, 1, 'h4};
        tbl[2]  = '{0, 0, 'h0, 1, 'h4, 1, 'h8};
        tbl[3]  = '{0, 0, 'h0, 1, 'h8, 1, 'hC};
        tbl[4]  = '{1, 0, 'h0, 1, 'h8, 0, 'h0};
        tbl[5]  = '{1, 0, 'h0, 1, 'h8, 0, 'h0};
        tbl[6]  = '{1, 0, 'h0, 1, 'h8, 0, 'h0};
        tbl[7]  = '{1, 0, 'h0, 1, 'h8, 0, 'h0};
        tbl[8]  = '{0, 0, 'h0, 1, 'hC, 1, 'h10};
        tbl[9]  = '{0, 0, 'h0, 1, 'h10, 1, 'h14};
        tbl[10] = '{1, 1, 'h43, 0, 'h0, 1, 'h40};
        tbl[11] = '{0, 0, 'h0, 1, 'h40, 1, 'h44};
        tbl[12] = '{0, 0, 'h0, 1, 'h44, 1, 'h48};
        tbl[13] = '{1, 0, 'h0, 1, 'h44, 0, 'h0};
        tbl[14] = '{1, 1, 32'hFFFF_FFFC, 0, 'h0, 1, 32'hFFFF_FFFC};
        tbl[15] = '{0, 0, 'h0, 1, 32'hFFFF_FFFC, 1, 'h0};
        tbl[16] = '{0, 0, 'h0, 1, 'h0, 1, 'h4};
        tbl[17] = '{0, 0, 'h0, 1, 'h4, 1, 'h8};
        @(posedge clk);
        #1 chk_reset("por");
        do_reset();
        for (int i = 0; i < 18; i++) begin
            stall_i = tbl[i].stall != 0;
            redirect_i = tbl[i].redir != 0;
            redirect_pc_i = tbl[i].rpc;
            @(posedge clk);
            #1 chk_state($sformatf("vec%0d", i), tbl[i].valid, tbl[i].pc, tbl[i].req, tbl[i].addr);
        end
        // three wait cycles per request: address held, one IF/ID entry per ack
        mem_lat = 3;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1 chk_state($sformatf("slow%0d", k), int'(k > 1 && (k - 1) % 4 == 0),
                         32'(4 * ((k - 1) / 4 - 1)), 1, 32'(4 * ((k - 1) / 4)));
        end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        @(posedge clk);
        #1 redirect_i = 1'b0;
        chk_state("drain", 0, 32'h0, 1, 32'h8);
        n = 0;
        while (imem_addr == 32'h8 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        chk_state("drain exit", 0, 32'h0, 1, 32'h40);
        n = 0;
        while (!ifid_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        chk_state("target", 1, 32'h40, 1, 32'h44);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h80;
        @(posedge clk);
        #1 redirect_i = 1'b0;
        chk_state("drain2", 0, 32'h0, 1, 32'h44);
        @(negedge clk);
        reset = 1'b1;
        #1 chk_reset("async");
        // random latency/stall/redirect: decode must see program order restarting at each target
        mem_rand = 1'b1;
        do_reset();
        exp_pc = '0;
        for (int c = 0; c < 3000; c++) begin
            stall_i = $urandom_range(0, 9) < 3;
            redirect_i = $urandom_range(0, 24) == 0;
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFF);
            @(negedge clk);
            if (prev_req && !prev_ack && imem_req) chk("hold addr", imem_addr, prev_addr);
            prev_req = imem_req;
            prev_ack = imem_ack;
            prev_addr = imem_addr;
            if (!ifid_valid) chk("rand nop", ifid_instr, 32'h0);
            if (redirect_i)
                exp_pc = {redirect_pc_i[31:2], 2'b00};
            else if (ifid_valid && !stall_i) begin
                chk("rand pc", ifid_pc, exp_pc);
                chk("rand pc4", ifid_pc4, exp_pc + 32'd4);
                chk("rand instr", ifid_instr, tag(exp_pc));
                exp_pc += 32'd4;
                consumed++;
            end
            @(posedge clk);
            #1;
        end
        chk("liveness", 32'(consumed > 200), 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
